regfile_mp_scoreboard: RTL and testbench
========================================

Name: regfile_mp_scoreboard

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard for the multi-issue core.
- Generalises the dual-issue register file to NW write ports and NR read ports, with same-cycle write forwarding.
- Adds per-register busy tracking:
  - issue slots mark destination registers busy;
  - writebacks clear them;
  - a flush clears all.
- Sits between decode/issue (read and issue ports) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NR, 4, number of read ports.
- NW, 2, number of write ports; lower index has higher priority.
- NI, 2, number of issue (busy-set) slots.
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy.
- AW is a localparam, clog2(NREGS); it is not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NR*XLEN  read data, combinational.
- rd_busy  out  NR  1 = operand still pending; consumer must stall.
- wr_en  in  NW  write enables.
- wr_addr  in  NW*AW  write addresses.
- wr_data  in  NW*XLEN  write data.
- iss_en  in  NI  issue valid; marks iss_rd busy.
- iss_rd  in  NI*AW  issued destination registers.
- flush  in  1  clears all busy bits (pipeline squash).
- busy_vec  out  NREGS  raw scoreboard state, for debug and the issue checker.

Behaviour:
- Reset (asynchronous assert, released synchronously by the reset synchroniser upstream):
  - all registers <= 0;
  - all busy bits <= 0;
  - busy_vec = 0;
  - rd_busy = 0 and rd_data = 0 for every port while reset is held.
- Write, registered; updates visible the cycle after the edge:
  - port j writes regs[wr_addr_j] when wr_en_j is high, unless the address is 0 with ZERO_REG=1;
  - if several enabled ports hit the same address, the lowest index wins and the others are dropped;
  - different addresses all commit in the same cycle.
- Read, combinational, priority order for port k:
  - (a) ZERO_REG and addr==0 -> 0, busy 0;
  - (b) lowest-index enabled write port with wr_addr==addr -> its wr_data, busy 0 (same-cycle forward);
  - (c) otherwise regs[addr], busy = busy[addr].
- Read latency is 0 cycles; write-to-read through storage is 1 cycle; write-to-read through the forward path is 0 cycles.
- Scoreboard next-state for register r, evaluated in this priority:
  - 1. flush high -> busy[r] <= 0, regardless of iss_en and wr_en; register writes still commit during flush;
  - 2. any iss_en_i with iss_rd_i==r -> busy[r] <= 1; set beats a same-cycle clear, because the new producer is pending;
  - 3. any wr_en_j with wr_addr_j==r -> busy[r] <= 0;
  - 4. otherwise hold.
- Register 0 is never set busy when ZERO_REG=1.
- Duplicate iss_rd across slots in one cycle is legal; the result is a single busy bit, no counting.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- Reset asserted mid-operation clears data and busy immediately, with no dependence on the clock.
- Out-of-range addresses cannot occur because NREGS = 2^AW.
- Synthesis: the register array has no reset requirement beyond the stated async clear; the async clear is mandated here.

Test Plan:
1. Defaults, reset: assert reset with no clock edges -> rd_data all 0, busy_vec=0. Release, write wr_addr0=5 with data DEADBEEF. Next cycle rd_addr0=5 -> DEADBEEF, rd_busy0=0.
2. Write collision: wr_en=11, both addresses 7, data 11111111 (port0) and 22222222 (port1). Same cycle, read 7 -> 11111111 (forward). Next cycle regs[7]=11111111.
3. Zero register: write addr 0 with FFFFFFFF and iss_rd=0 -> reads of 0 return 0, busy_vec[0]=0.
4. Scoreboard lifecycle: issue rd=9 -> next cycle rd_busy=1 for addr 9. Writeback 9 with 00000042 -> same cycle rd_data=42, rd_busy=0; next cycle busy_vec[9]=0.
5. Simultaneous events on reg 12:
   - issue and writeback in the same cycle -> busy_vec[12]=1 after the edge, regs[12] updated;
   - flush plus issue of 12 and 13 -> busy_vec=0 after the edge.
6. Async reset mid-stream: busy_vec=0x00003200 and registers nonzero; pulse reset between clock edges -> busy_vec=0 and all reads 0 before the next edge.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with same-cycle write forwarding and a
// per-register pending-write scoreboard. Issue slots mark destinations busy,
// writebacks clear them, flush clears all. Reads are purely combinational.
module regfile_mp_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NR       = 4,
  parameter int NW       = 2,
  parameter int NI       = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic [NI-1:0]      iss_en,
  input  logic [NI*AW-1:0]   iss_rd,
  input  logic               flush,
  output logic [NREGS-1:0]   busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic [AW-1:0]    rd_a;
  logic             fwd_hit;

  // Merge write ports into next-state storage; walking from the highest index
  // down lets the lowest-index port overwrite any same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = NW - 1; j >= 0; j--) begin
      if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0))) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: flush clears all, then a new producer (set) wins
  // over a same-cycle writeback (clear), otherwise hold.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int i = 0; i < NI; i++) begin
      if (iss_en[i]) set_v[iss_rd[i*AW +: AW]] = 1'b1;
    end
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j]) clr_v[wr_addr[j*AW +: AW]] = 1'b1;
    end
    if (flush) busy_d = '0;
    else       busy_d = set_v | (busy_q & ~clr_v);
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Read ports: zero register, then forward from the lowest-index matching
  // write, then storage. Outputs are forced to zero while reset is held so the
  // forward path cannot leak write data during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    fwd_hit = 1'b0;
    for (int k = 0; k < NR; k++) begin
      rd_a    = rd_addr[k*AW +: AW];
      fwd_hit = 1'b0;
      if (!((ZERO_REG != 0) && (rd_a == '0))) begin
        for (int j = NW - 1; j >= 0; j--) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_a)) begin
            fwd_hit                   = 1'b1;
            rd_data[k*XLEN +: XLEN]   = wr_data[j*XLEN +: XLEN];
          end
        end
        if (!fwd_hit) begin
          rd_data[k*XLEN +: XLEN] = regs_q[rd_a];
          rd_busy[k]              = busy_q[rd_a];
        end
      end
    end
    if (reset) begin
      rd_data = '0;
      rd_busy = '0;
    end
  end

  // Storage and scoreboard state with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: read expectations are queued when
// the stimulus is driven and popped/compared once outputs have settled.
module tb_regfile_mp_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int NI    = 2;
  localparam int AW    = 5;

  logic               clk;
  logic               reset;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*XLEN-1:0] wr_data;
  logic [NI-1:0]      iss_en;
  logic [NI*AW-1:0]   iss_rd;
  logic               flush;
  logic [NREGS-1:0]   busy_vec;

  int vectors;
  int miscompares;

  logic [XLEN:0] exp_q[$];
  int            port_q[$];
  string         tag_q[$];

  regfile_mp_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW), .NI(NI), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_vec(busy_vec)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN:0] obs, input logic [XLEN:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic cyc();
    @(negedge clk);
    wr_en  = '0;
    iss_en = '0;
    flush  = 1'b0;
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[j]               = 1'b1;
    wr_addr[j*AW +: AW]    = a;
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input int i, input logic [AW-1:0] a);
    iss_en[i]           = 1'b1;
    iss_rd[i*AW +: AW]  = a;
  endtask

  task automatic rd_expect(input string tag, input int k, input logic [AW-1:0] a,
                           input logic b, input logic [XLEN-1:0] d);
    rd_addr[k*AW +: AW] = a;
    exp_q.push_back({b, d});
    port_q.push_back(k);
    tag_q.push_back(tag);
  endtask

  // Scoreboard
  task automatic drain();
    logic [XLEN:0] e;
    int            p;
    string         t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = port_q.pop_front();
      t = tag_q.pop_front();
      check(t, {rd_busy[p], rd_data[p*XLEN +: XLEN]}, e);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset   = 1'b0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_en  = '0;
    iss_rd  = '0;
    flush   = 1'b0;

    // Reset held, no clock edge yet; forward path must be gated too
    #1 reset = 1'b1;
    wr(0, 5'd3, 32'h12345678);
    rd_expect("rst_fwd_gated", 0, 5'd3, 1'b0, 32'h0);
    rd_expect("rst_p1", 1, 5'd5, 1'b0, 32'h0);
    rd_expect("rst_p2", 2, 5'd31, 1'b0, 32'h0);
    #1 drain();
    check("rst_busy_vec", {1'b0, busy_vec}, '0);
    cyc();
    cyc();
    reset = 1'b0;

    // Basic write, forward then storage
    cyc();
    wr(0, 5'd5, 32'hDEADBEEF);
    rd_expect("t1_fwd", 0, 5'd5, 1'b0, 32'hDEADBEEF);
    #1 drain();
    cyc();
    rd_expect("t1_store", 0, 5'd5, 1'b0, 32'hDEADBEEF);
    #1 drain();

    // Write collision: port 0 wins
    cyc();
    wr(0, 5'd7, 32'h11111111);
    wr(1, 5'd7, 32'h22222222);
    rd_expect("t2_fwd_p0", 0, 5'd7, 1'b0, 32'h11111111);
    rd_expect("t2_fwd_p3", 3, 5'd7, 1'b0, 32'h11111111);
    #1 drain();
    cyc();
    rd_expect("t2_store", 1, 5'd7, 1'b0, 32'h11111111);
    #1 drain();

    // Two different addresses commit together
    cyc();
    wr(0, 5'd3, 32'hA0A0A0A0);
    wr(1, 5'd4, 32'hB0B0B0B0);
    cyc();
    rd_expect("par_r3", 0, 5'd3, 1'b0, 32'hA0A0A0A0);
    rd_expect("par_r4", 1, 5'd4, 1'b0, 32'hB0B0B0B0);
    #1 drain();

    // Zero register
    cyc();
    wr(0, 5'd0, 32'hFFFFFFFF);
    iss(0, 5'd0);
    rd_expect("t3_fwd", 0, 5'd0, 1'b0, 32'h0);
    #1 drain();
    cyc();
    rd_expect("t3_store", 2, 5'd0, 1'b0, 32'h0);
    #1 drain();
    check("t3_busy_vec", {1'b0, busy_vec}, '0);

    // Scoreboard lifecycle on r9
    cyc();
    iss(1, 5'd9);
    cyc();
    rd_expect("t4_busy", 0, 5'd9, 1'b1, 32'h0);
    #1 drain();
    check("t4_busy_vec", {1'b0, busy_vec}, 33'h0000_0200);
    wr(1, 5'd9, 32'h00000042);
    rd_expect("t4_fwd", 0, 5'd9, 1'b0, 32'h00000042);
    #1 drain();
    cyc();
    #1 check("t4_clear", {1'b0, busy_vec}, '0);
    rd_expect("t4_store", 0, 5'd9, 1'b0, 32'h00000042);
    #1 drain();

    // Issue and writeback of r12 in the same cycle: set wins, data commits
    cyc();
    iss(0, 5'd12);
    wr(1, 5'd12, 32'hABCD0012);
    cyc();
    #1 check("t5_set_wins", {1'b0, busy_vec}, 33'h0000_1000);
    rd_expect("t5_data", 2, 5'd12, 1'b1, 32'hABCD0012);
    #1 drain();

    // Flush beats issue; a write during flush still commits
    cyc();
    flush = 1'b1;
    iss(0, 5'd12);
    iss(1, 5'd13);
    wr(0, 5'd20, 32'h20202020);
    cyc();
    #1 check("t5_flush", {1'b0, busy_vec}, '0);
    rd_expect("t5_flush_wr", 3, 5'd20, 1'b0, 32'h20202020);
    #1 drain();

    // Duplicate issue gives one busy bit; writeback to a non-busy register
    cyc();
    iss(0, 5'd14);
    iss(1, 5'd14);
    cyc();
    #1 check("dup_iss", {1'b0, busy_vec}, 33'h0000_4000);
    wr(0, 5'd14, 32'h00000014);
    wr(1, 5'd15, 32'h00000015);
    cyc();
    #1 check("dup_clear", {1'b0, busy_vec}, '0);
    rd_expect("nonbusy_wb", 1, 5'd15, 1'b0, 32'h00000015);
    #1 drain();

    // Build busy_vec = 0x3200, then async reset between edges
    cyc();
    iss(0, 5'd9);
    iss(1, 5'd12);
    wr(0, 5'd9, 32'h00000099);
    cyc();
    iss(0, 5'd13);
    cyc();
    #1 check("t6_pre", {1'b0, busy_vec}, 33'h0000_3200);
    rd_expect("t6_pre_r9", 0, 5'd9, 1'b1, 32'h00000099);
    #1 drain();
    #1 reset = 1'b1;
    #1 check("t6_async_busy", {1'b0, busy_vec}, '0);
    rd_expect("t6_r5", 0, 5'd5, 1'b0, 32'h0);
    rd_expect("t6_r7", 1, 5'd7, 1'b0, 32'h0);
    rd_expect("t6_r12", 2, 5'd12, 1'b0, 32'h0);
    rd_expect("t6_r9", 3, 5'd9, 1'b0, 32'h0);
    drain();
    cyc();
    reset = 1'b0;
    rd_expect("t6_post_r5", 0, 5'd5, 1'b0, 32'h0);
    rd_expect("t6_post_r20", 1, 5'd20, 1'b0, 32'h0);
    #1 drain();
    check("t6_post_busy", {1'b0, busy_vec}, '0);

    // Final report
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
